// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
// i2c_pkg: FSM states, ACK levels and default device address shared by the I2C register target
package i2c_pkg;
   typedef enum logic [3:0] {IDLE, DEV, ACK_DEV, REG, ACK_REG, WR, ACK_WR, RD, MACK} state_t;
   localparam logic ACK = 1'b0;
   localparam logic NACK = 1'b1;
   localparam logic [6:0] DEF_DEV_ADDR = 7'h50;
endpackage

// File: rtl/i2c_reg_slave_if.sv
`timescale 1ns/1ps
// i2c_reg_slave_if: scl input and write-notification outputs of the I2C register target
interface i2c_reg_slave_if #(parameter int REG_AW = 4);
   logic scl;
   logic po_flag;
   logic [REG_AW-1:0] wr_addr;
   logic [7:0] wr_data;
   modport slave (input scl, output po_flag, wr_addr, wr_data);
   modport master (output scl, input po_flag, wr_addr, wr_data);
endinterface

// File: rtl/i2c_line_sync.sv
`timescale 1ns/1ps
// i2c_line_sync: synchronises scl/sda into sys_clk and emits edge, START and STOP strobes
module i2c_line_sync (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic scl,
   input  logic sda,
   output logic sda_s,
   output logic scl_pos,
   output logic scl_neg,
   output logic start_det,
   output logic stop_det
);
   logic [2:0] scl_r, sda_r;
   // reset to the idle-bus level so releasing reset never fakes an edge
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         scl_r <= '1;
         sda_r <= '1;
      end else begin
         scl_r <= {scl_r[1:0], scl};
         sda_r <= {sda_r[1:0], sda};
      end
   assign sda_s = sda_r[1];
   assign scl_pos = scl_r[1] & ~scl_r[2];
   assign scl_neg = ~scl_r[1] & scl_r[2];
   assign start_det = scl_r[1] & scl_r[2] & sda_r[2] & ~sda_r[1];
   assign stop_det = scl_r[1] & scl_r[2] & ~sda_r[2] & sda_r[1];
endmodule

// File: rtl/i2c_reg_slave.sv
`timescale 1ns/1ps
// i2c_reg_slave: I2C target with a byte register bank, auto-incrementing pointer and write strobe
module i2c_reg_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
   parameter int REG_NUM = 16,
   parameter int REG_AW = 4
) (
   input logic sys_clk,
   input logic sys_rst_n,
   inout wire sda,
   i2c_reg_slave_if.slave bus
);
   state_t state, state_nx;
   logic [7:0] bank [REG_NUM];
   logic [7:0] sh, sh_nx, byte_in;
   logic [2:0] cnt, cnt_nx;
   logic [REG_AW-1:0] ptr, ptr_nx;
   logic sda_oe, oe_nx, wr_en, last;
   logic sda_s, scl_pos, scl_neg, start_det, stop_det;
   i2c_line_sync u_sync (
      .sys_clk(sys_clk),
      .sys_rst_n(sys_rst_n),
      .scl(bus.scl),
      .sda(sda),
      .sda_s(sda_s),
      .scl_pos(scl_pos),
      .scl_neg(scl_neg),
      .start_det(start_det),
      .stop_det(stop_det)
   );
   assign sda = sda_oe ? 1'b0 : 1'bz;
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         state <= IDLE;
         sh <= '0;
         cnt <= '0;
         ptr <= '0;
         sda_oe <= 1'b0;
         bus.po_flag <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= '0;
         for (int i = 0; i < REG_NUM; i++) bank[i] <= '0;
      end else begin
         state <= state_nx;
         sh <= sh_nx;
         cnt <= cnt_nx;
         ptr <= ptr_nx;
         sda_oe <= oe_nx;
         bus.po_flag <= wr_en;
         if (wr_en) begin
            bank[ptr] <= byte_in;
            bus.wr_addr <= ptr;
            bus.wr_data <= byte_in;
         end
      end
   // oe only moves on scl fall, so the ACK slot spans exactly one scl period
   always_comb begin
      byte_in = {sh[6:0], sda_s};
      last = cnt == 3'd7;
      state_nx = state;
      sh_nx = sh;
      cnt_nx = cnt;
      ptr_nx = ptr;
      oe_nx = sda_oe;
      wr_en = 1'b0;
      if (stop_det || start_det) begin
         state_nx = stop_det ? IDLE : DEV;
         cnt_nx = 3'd0;
         oe_nx = 1'b0;
      end else if (scl_neg)
         oe_nx = (state == ACK_DEV || state == ACK_REG || state == ACK_WR) ? 1'b1 : (state == RD) ? ~sh[7] : 1'b0;
      else if (scl_pos)
         case (state)
            DEV, REG, WR: begin
               sh_nx = byte_in;
               cnt_nx = cnt + 3'd1;
               if (last) begin
                  state_nx = state == DEV ? (byte_in[7:1] == DEV_ADDR ? ACK_DEV : IDLE) : state == REG ? ACK_REG : ACK_WR;
                  ptr_nx = state == REG ? byte_in[REG_AW-1:0] : state == WR ? ptr + 1'b1 : ptr;
                  wr_en = state == WR;
               end
            end
            ACK_DEV: begin
               state_nx = sh[0] ? RD : REG;
               sh_nx = sh[0] ? bank[ptr] : sh;
               cnt_nx = 3'd0;
            end
            ACK_REG, ACK_WR: begin
               state_nx = WR;
               cnt_nx = 3'd0;
            end
            RD: begin
               sh_nx = {sh[6:0], 1'b0};
               cnt_nx = cnt + 3'd1;
               if (last) begin
                  state_nx = MACK;
                  ptr_nx = ptr + 1'b1;
               end
            end
            MACK: begin
               state_nx = sda_s == ACK ? RD : IDLE;
               sh_nx = bank[ptr];
               cnt_nx = 3'd0;
            end
            default: ;
         endcase
   end
endmodule
